// File: rtl/audio_nios_pio_led_pkg.sv
// Shared constants for the LED/output PIO: register map, field widths and pulse FSM states.
package audio_nios_pio_led_pkg;

  localparam int unsigned ADDR_W         = 3;
  localparam int unsigned BUS_W          = 32;
  localparam int unsigned PULSE_LEN_W    = 16;
  localparam int unsigned BLINK_PERIOD_W = 24;

  localparam logic [ADDR_W-1:0] ADDR_DATA         = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PULSE        = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET       = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR     = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_PERIOD = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_STATUS       = 3'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/audio_nios_pio_led_blink.sv
// Blink phase generator: phase toggles every `period` cycles; period 0 parks it low.
module audio_nios_pio_led_blink
  import audio_nios_pio_led_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BLINK_PERIOD_W-1:0] period,
  input  logic                      period_wr,
  output logic                      phase
);

  logic [BLINK_PERIOD_W-1:0] cnt;

  // A period rewrite restarts the pattern from a known low phase.
  always_ff @(posedge clk) begin
    if (reset || period_wr || (period == '0)) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == period - BLINK_PERIOD_W'(1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + BLINK_PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/audio_nios_pio_led.sv
// Avalon-MM LED/output PIO with set/clear, timed pulses, blinking and a pulse-done interrupt.
module audio_nios_pio_led
  import audio_nios_pio_led_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  logic                      wr;
  logic [WIDTH-1:0]          wd;
  logic                      unused_wd;

  logic [WIDTH-1:0]          data;
  logic [WIDTH-1:0]          blink_mask;
  logic [PULSE_LEN_W-1:0]    pulse_len;
  logic [BLINK_PERIOD_W-1:0] blink_period;

  pulse_state_t              state;
  logic [WIDTH-1:0]          active;
  logic [WIDTH-1:0]          done;
  logic [PULSE_LEN_W-1:0]    count;

  logic                      pulse_wr;
  logic                      expire;
  logic [PULSE_LEN_W-1:0]    load_count;
  logic [WIDTH-1:0]          status_clr;
  logic [WIDTH-1:0]          done_next;
  logic [BUS_W-1:0]          rd_mux;
  logic                      phase;

  assign wr        = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata[BUS_W-1:BLINK_PERIOD_W];

  // Programmable registers; OUTSET/OUTCLEAR act on DATA and hold no state of their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      data         <= '0;
      blink_mask   <= '0;
      pulse_len    <= PULSE_LEN_W'(1);
      blink_period <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:         data         <= wd;
        ADDR_OUTSET:       data         <= data | wd;
        ADDR_OUTCLEAR:     data         <= data & ~wd;
        ADDR_PULSE_LEN:    pulse_len    <= writedata[PULSE_LEN_W-1:0];
        ADDR_BLINK_MASK:   blink_mask   <= wd;
        ADDR_BLINK_PERIOD: blink_period <= writedata[BLINK_PERIOD_W-1:0];
        default: ;
      endcase
    end
  end

  // A zero-length pulse still lasts one cycle so a start is never silently lost.
  assign pulse_wr   = wr && (address == ADDR_PULSE) && (wd != '0);
  assign load_count = (pulse_len == '0) ? PULSE_LEN_W'(1) : pulse_len;
  assign expire     = (state == ACTIVE) && (count == PULSE_LEN_W'(1));
  assign status_clr = (wr && (address == ADDR_STATUS)) ? wd : '0;
  assign done_next  = (done & ~status_clr) | (expire ? active : '0);

  // Pulse FSM; irq follows done_next so it tracks |done with no extra lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      active <= '0;
      count  <= '0;
      done   <= '0;
      irq    <= 1'b0;
    end else begin
      done <= done_next;
      irq  <= |done_next;
      case (state)
        IDLE: begin
          if (pulse_wr) begin
            active <= wd;
            count  <= load_count;
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (expire) begin
            if (pulse_wr) begin
              active <= wd;
              count  <= load_count;
            end else begin
              active <= '0;
              count  <= '0;
              state  <= IDLE;
            end
          end else if (pulse_wr) begin
            active <= active | wd;
            count  <= load_count;
          end else begin
            count  <= count - PULSE_LEN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  audio_nios_pio_led_blink u_blink (
    .clk       (clk),
    .reset     (reset),
    .period    (blink_period),
    .period_wr (wr && (address == ADDR_BLINK_PERIOD)),
    .phase     (phase)
  );

  // Read mux; write-only and strobe registers read back as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:         rd_mux = BUS_W'(data);
      ADDR_PULSE_LEN:    rd_mux = BUS_W'(pulse_len);
      ADDR_PULSE:        rd_mux = BUS_W'(active);
      ADDR_BLINK_MASK:   rd_mux = BUS_W'(blink_mask);
      ADDR_BLINK_PERIOD: rd_mux = BUS_W'(blink_period);
      ADDR_STATUS: begin
        rd_mux            = BUS_W'(done);
        rd_mux[BUS_W-1]   = (state == ACTIVE);
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      out_port <= '0;
    end else begin
      readdata <= rd_mux;
      out_port <= ((data & ~blink_mask) | (blink_mask & {WIDTH{phase}})) | active;
    end
  end

endmodule

// File: doc/audio_nios_pio_led.md
AUDIO_NIOS_PIO_LED -- requirements
Module: audio_nios_pio_led

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10: number of output bits driven on out_port.
REQ-002 The block SHALL have port clk, input, 1: single clock for all logic.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port address, input, 3: Avalon-MM slave word address.
REQ-005 The block SHALL have port chipselect, input, 1: slave select.
REQ-006 The block SHALL have port write_n, input, 1: active-low write strobe; a write is chipselect && !write_n.
REQ-007 The block SHALL have port writedata, input, 32: write data.
REQ-008 The block SHALL have port readdata, output, 32: registered read data, unused upper bits 0.
REQ-009 The block SHALL have port out_port, output, WIDTH: driven LED/output pins.
REQ-010 The block SHALL have port irq, output, 1: pulse-complete interrupt, level.

Function
REQ-011 The register map SHALL be fixed as follows:
- 0 DATA (RW, WIDTH)
- 1 PULSE_LEN (RW, 16)
- 2 PULSE (W: start mask; R: active mask)
- 3 BLINK_MASK (RW, WIDTH)
- 4 OUTSET (W1S to DATA, reads 0)
- 5 OUTCLEAR (W1C to DATA, reads 0)
- 6 BLINK_PERIOD (RW, 24)
- 7 STATUS (R: done mask; W1C; bit 31 = pulse busy)
REQ-012 readdata SHALL update every clock from the address-selected mux, with 1-cycle latency and no dependence on chipselect.
REQ-013 out_port SHALL be the registered value of ((DATA & ~BLINK_MASK) | (BLINK_MASK & {WIDTH{phase}})) | active, updated 1 cycle after any contributing state changes.
REQ-014 The pulse FSM SHALL have two states, IDLE and ACTIVE; a PULSE write with a nonzero mask SHALL load active = mask and count = max(PULSE_LEN,1), then enter ACTIVE.
REQ-015 In ACTIVE, count SHALL decrement once per cycle; at count==1, the FSM SHALL set done |= active, clear active and return to IDLE, so each pulse bit is high in the internal active mask for exactly max(PULSE_LEN,1) cycles.
REQ-016 A PULSE write while ACTIVE SHALL OR the new mask into active and reload count; a PULSE write with a zero mask SHALL have no effect.
REQ-017 When a PULSE write coincides with the expiry cycle, the block SHALL set done for the old bits, set active to the new mask only, and reload count.
REQ-018 The blink counter SHALL count 0..BLINK_PERIOD-1, toggling phase and wrapping to 0 at the terminal value.
REQ-019 When BLINK_PERIOD==0, the blink counter and phase SHALL both be held at 0.
REQ-020 Any BLINK_PERIOD write SHALL clear both the blink counter and phase.
REQ-021 irq SHALL equal |done.
REQ-022 When a STATUS W1C write and a done-set fall on the same cycle for the same bit, the set SHALL win.
REQ-023 Writes to undecoded bits SHALL be ignored, and reads of write-only fields SHALL return 0 except where REQ-011 defines a read value.

Reset
REQ-024 While reset is high at a clk edge, the block SHALL set DATA, BLINK_MASK, active, done, count, blink counter and phase to 0, PULSE_LEN to 1, BLINK_PERIOD to 0 and the FSM to IDLE; readdata, out_port and irq SHALL be 0 on the following cycle.
REQ-025 Reset asserted mid-pulse SHALL abort the pulse without setting done.

Structure
REQ-026 Package audio_nios_pio_led_pkg SHALL hold the register address constants, the PULSE_LEN/BLINK_PERIOD widths and the FSM state enumeration.
REQ-027 The blink counter/phase generator SHALL be the sub-module audio_nios_pio_led_blink (inputs: period, period_wr; output: phase).

Verification
REQ-028 The bench SHALL check reset: out of reset, read all eight addresses -> DATA=0, PULSE_LEN=1, others 0; out_port=0; irq=0.
REQ-029 The bench SHALL check set/clear: write DATA=0x0F0, OUTSET=0x003, OUTCLEAR=0x010 -> read DATA=0x0E3 and out_port=0x0E3.
REQ-030 The bench SHALL check a single pulse: PULSE_LEN=5, PULSE=0x200 -> out_port[9] high exactly 5 cycles, STATUS=0x200, irq=1; STATUS write 0x200 -> irq=0.
REQ-031 The bench SHALL check pulse retrigger: PULSE_LEN=4, PULSE=0x001, then PULSE=0x002 two cycles later -> bit0 high 6 cycles, bit1 high 4 cycles, done=0x003 at the end.
REQ-032 The bench SHALL check blink: BLINK_PERIOD=3, BLINK_MASK=0x100, DATA=0 -> out_port[8] toggles every 3 cycles; writing BLINK_PERIOD=0 -> out_port[8]=0 held.
REQ-033 The bench SHALL check reset mid-pulse: PULSE_LEN=100, PULSE=0x3FF, reset at cycle 10 -> out_port=0, STATUS=0, irq=0 and FSM IDLE (PULSE read returns 0).
